// File: rtl/dram_fifo_nxd_pkg.sv
// Shared helpers for the HDMI/DVI buffer family: depth derivation,
// ceil-log2 and parameter legality checks for distributed-RAM FIFOs.
package dram_fifo_nxd_pkg;

  localparam int DEFAULT_DATA_WIDTH = 20;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int MIN_ADDR_WIDTH     = 2;
  localparam int MAX_ADDR_WIDTH     = 8;

  // Ceil-log2 of a positive value (returns 0 for values <= 1).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'sd1 <<< res) < value) begin
        res = res + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Number of words addressed by an ADDR_WIDTH-bit pointer.
  function automatic int depth_of(input int addr_width);
    return 32'sd1 <<< addr_width;
  endfunction

  // True when the geometry and thresholds form a usable FIFO.
  function automatic bit params_legal(input int data_width, input int addr_width,
                                      input int af_thresh, input int ae_thresh);
    int depth;
    depth = depth_of(addr_width);
    return (data_width >= 1) &&
           (addr_width >= MIN_ADDR_WIDTH) && (addr_width <= MAX_ADDR_WIDTH) &&
           (clog2(depth) == addr_width) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh < depth);
  endfunction

endpackage

// File: rtl/dram_fifo_nxd_if.sv
// FIFO access bus: write/read requests, data, status and error flags.
interface dram_fifo_nxd_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  // Client side: issues requests, observes data and status.
  modport master (
    output flush, wr_en, din, rd_en, err_clr,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // FIFO side: accepts requests, drives data and status.
  modport slave (
    input  flush, wr_en, din, rd_en, err_clr,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/dram_fifo_nxd_dp.sv
// 2^ADDR_WIDTH x DATA_WIDTH distributed dual-port RAM: synchronous write
// through port A, asynchronous reads on SPO (port A) and DPO (port B).
module dram_dp_nxd #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0] dpra,
  output logic [DATA_WIDTH-1:0] spo,
  output logic [DATA_WIDTH-1:0] dpo
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage is deliberately not reset so it maps onto LUT RAM.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port: one word per enabled clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[a] <= d;
    end
  end

  assign spo = mem_r[a];
  assign dpo = mem_r[dpra];
endmodule

// File: rtl/dram_fifo_nxd.sv
// Single-clock FIFO over distributed dual-port RAM used as the TMDS
// channel-bonding / pixel-skew buffer. Pointers, occupancy, registered
// threshold flags, flush and sticky error reporting live here.
module dram_fifo_nxd
  import dram_fifo_nxd_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 3
) (
  input logic            clk,
  input logic            rst,
  dram_fifo_nxd_if.slave bus
);
  localparam int                  DEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (!params_legal(DATA_WIDTH, ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_param_check
    $error("dram_fifo_nxd: illegal geometry or thresholds");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  full_r;
  logic                  empty_r;
  logic                  almost_full_r;
  logic                  almost_empty_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  dout_valid_r;

  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ov_set_s;
  logic                  uf_set_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [DATA_WIDTH-1:0] unused_spo_s;

  // Accept decisions use the registered flags; flush blocks both ports.
  always_comb begin
    wr_acc_s    = bus.wr_en & ~full_r  & ~bus.flush;
    rd_acc_s    = bus.rd_en & ~empty_r & ~bus.flush;
    ov_set_s    = bus.wr_en &  full_r  & ~bus.flush;
    uf_set_s    = bus.rd_en &  empty_r & ~bus.flush;
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + (ADDR_WIDTH+1)'(1'b1);
      2'b01:   count_nxt_s = count_r - (ADDR_WIDTH+1)'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  dram_dp_nxd #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc_s),
    .a    (wr_ptr_r),
    .d    (bus.din),
    .dpra (rd_ptr_r),
    .spo  (unused_spo_s),
    .dpo  (rd_data_s)
  );

  // Pointers, occupancy and flags; flags track the next occupancy so they
  // move on the same edge as the count.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1'b1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1'b1);
      end
      count_r        <= count_nxt_s;
      full_r         <= (count_nxt_s == DEPTH_C);
      empty_r        <= (count_nxt_s == '0);
      almost_full_r  <= (count_nxt_s >= AF_C);
      almost_empty_r <= (count_nxt_s <= AE_C);
    end
  end

  // Registered read data: DOUT holds between reads, valid pulses per read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= rd_acc_s;
      if (rd_acc_s) begin
        dout_r <= rd_data_s;
      end
    end
  end

  // Sticky error flags; a fresh error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ov_set_s | (overflow_r  & ~bus.err_clr);
      underflow_r <= uf_set_s | (underflow_r & ~bus.err_clr);
    end
  end

  assign bus.dout         = dout_r;
  assign bus.dout_valid   = dout_valid_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = almost_full_r;
  assign bus.almost_empty = almost_empty_r;
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_dram_fifo_nxd.sv
// Scoreboard bench for dram_fifo_nxd: a queue-based reference model predicts
// status every cycle and pushes expected read words; a negedge monitor pops
// and compares whenever DOUT_VALID is seen.
module tb_dram_fifo_nxd;
  localparam int DW    = 20;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 3;

  logic clk;
  logic rst;

  dram_fifo_nxd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dram_fifo_nxd #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 1'b0;
  bit            m_ov = 1'b0;
  bit            m_uf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts the state after the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit f, input bit ec, input bit rs);
    bit wa, ra, ov_set, uf_set;
    int n;
    bus.wr_en   = w;
    bus.din     = d;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.err_clr = ec;
    rst         = rs;
    n = mq.size();
    if (rs) begin
      mq.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
      m_dout = '0;
      m_valid = 1'b0;
    end else begin
      wa     = w && !f && (n < DEPTH);
      ra     = r && !f && (n > 0);
      ov_set = w && !f && (n == DEPTH);
      uf_set = r && !f && (n == 0);
      m_ov   = ov_set || (m_ov && !ec);
      m_uf   = uf_set || (m_uf && !ec);
      m_valid = ra;
      if (ra) begin
        m_dout = mq.pop_front();
        exp_q.push_back(m_dout);
      end
      if (wa) mq.push_back(d);
      if (f) mq.delete();
    end
    @(posedge clk);
    #1;
    n = mq.size();
    chk("count",        32'(bus.count),        32'(n));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("full",         32'(bus.full),         32'(n == DEPTH));
    chk("almost_full",  32'(bus.almost_full),  32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
    chk("overflow",     32'(bus.overflow),     32'(m_ov));
    chk("underflow",    32'(bus.underflow),    32'(m_uf));
    chk("dout_valid",   32'(bus.dout_valid),   32'(m_valid));
    chk("dout_hold",    32'(bus.dout),         32'(m_dout));
  endtask

  // Monitor: every DOUT_VALID pulse must match the oldest expected word.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %0h, expected no output at %0t", bus.dout, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_dout", 32'(bus.dout), 32'(e));
        end
      end
    end
  end

  initial begin
    int wp, rp;
    bus.wr_en = 1'b0; bus.din = '0; bus.rd_en = 1'b0;
    bus.flush = 1'b0; bus.err_clr = 1'b0; rst = 1'b1;

    // Reset state
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 1);

    // Fill with 1..16, no reads
    for (int i = 1; i <= 16; i++) step(1, DW'(i), 0, 0, 0, 0);

    // Full: write+read together -> read only, overflow; then clear
    step(1, 20'h00077, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);

    // Drain to 5 then 40 cycles of streaming across pointer wrap
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, DW'($urandom), 1, 0, 0, 0);

    // Empty: underflow, then write+read together
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(1, 20'h0abcd, 1, 0, 0, 0);

    // Grow to 9 then flush with a write pending
    for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, 0, 0, 0);
    step(1, 20'h0dead, 0, 1, 0, 0);
    step(1, 20'h01234, 0, 0, 1, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);

    // Reset mid-burst at count 7, then single write/read
    for (int i = 0; i < 7; i++) step(1, DW'($urandom), 0, 0, 0, 0);
    step(1, 20'h05555, 1, 0, 0, 1);
    step(1, 20'h0cafe, 0, 0, 0, 0);
    step(0, '0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);

    // Randomized phases with varying write/read bias
    for (int blk = 0; blk < 12; blk++) begin
      wp = (blk % 3 == 0) ? 80 : ((blk % 3 == 1) ? 20 : 50);
      rp = 100 - wp;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < wp, DW'($urandom),
             $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 5,
             $urandom_range(0, 999) < 4);
      end
    end

    // Idle and make sure every predicted read was observed
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
